// File: rtl/cache_control_pkg.sv
// Shared cache-controller types: the controller FSM state encoding.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [width-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/cache_control.sv
// Two-way cache controller: zero-wait hits, optional writeback, then line fill;
// also keeps saturating hit/miss statistics.
module cache_control
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       hit,
    input  logic             lru_out,
    input  logic             dirty_mux_out,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             tag_write,
    output logic             retain,
    output logic             cache_write,
    output logic             dirty_set,
    output logic             dirty_reset,
    output logic             lru_write,
    output logic             valid_write,
    output logic             pmem_addr_sel,
    output logic             save_to_cache_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    cache_state_t state, state_next;
    logic         req;
    logic         miss_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the IDLE outputs are Mealy decodes of the request inputs, so the
    // request is qualified with rst_n to keep every strobe low during reset.
    assign req = (mem_read | mem_write) & rst_n;

    // NOTE: every output and the next state get a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next        = state;
        mem_resp          = 1'b0;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        tag_write         = 1'b0;
        retain            = 1'b0;
        cache_write       = 1'b0;
        dirty_set         = 1'b0;
        dirty_reset       = 1'b0;
        lru_write         = 1'b0;
        valid_write       = 1'b0;
        pmem_addr_sel     = 1'b0;
        save_to_cache_sel = 1'b0;
        miss_evt          = 1'b0;

        case (state)
            IDLE: begin
                if (req && (hit != 2'b00)) begin
                    mem_resp  = 1'b1;
                    // Touching the current victim moves it off the LRU slot.
                    lru_write = (hit[1] == lru_out);
                    if (mem_write) begin
                        cache_write       = 1'b1;
                        save_to_cache_sel = 1'b1;
                        dirty_set         = 1'b1;
                    end
                end else if (req) begin
                    miss_evt = 1'b1;
                    if (dirty_mux_out) begin
                        retain     = 1'b1;
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    state_next = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read = 1'b1;
                // A dropped request still finishes the fill; IDLE then sees no request.
                if (pmem_resp) begin
                    tag_write   = 1'b1;
                    valid_write = 1'b1;
                    dirty_reset = 1'b1;
                    state_next  = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    sat_counter #(.width(CNT_W)) hit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_resp),
        .count (hit_count)
    );

    sat_counter #(.width(CNT_W)) miss_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_evt),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: decode table, hand-written miss and
// reset sequences, then random traffic against a transaction-level model.
module tb_cache_control;

    logic clk, rst_n;
    logic mem_read, mem_write, lru_out, dirty_mux_out, pmem_resp;
    logic [1:0] hit;

    logic mem_resp, pmem_read, pmem_write, tag_write, retain, cache_write;
    logic dirty_set, dirty_reset, lru_write, valid_write, pmem_addr_sel, save_to_cache_sel;
    logic [15:0] hit_count, miss_count;

    logic s_mem_resp, s_pmem_read, s_pmem_write, s_tag_write, s_retain, s_cache_write;
    logic s_dirty_set, s_dirty_reset, s_lru_write, s_valid_write, s_pmem_addr_sel, s_save_sel;
    logic [1:0] s_hit_count, s_miss_count;

    int checks = 0;
    int failures = 0;

    localparam logic [11:0] M_RESP = 12'h800, M_PRD = 12'h400, M_PWR = 12'h200,
                            M_TAG  = 12'h100, M_RET = 12'h080, M_CW  = 12'h040,
                            M_DSET = 12'h020, M_DRST = 12'h010, M_LRU = 12'h008,
                            M_VAL  = 12'h004, M_ASEL = 12'h002, M_SSEL = 12'h001;
    localparam logic [11:0] M_FILL_DONE = M_PRD | M_TAG | M_VAL | M_DRST;
    localparam logic [11:0] M_WHIT = M_RESP | M_CW | M_SSEL | M_DSET;

    logic [11:0] outs;
    assign outs = {mem_resp, pmem_read, pmem_write, tag_write, retain, cache_write,
                   dirty_set, dirty_reset, lru_write, valid_write, pmem_addr_sel,
                   save_to_cache_sel};

    cache_control dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .lru_out(lru_out), .dirty_mux_out(dirty_mux_out), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .tag_write(tag_write), .retain(retain), .cache_write(cache_write),
        .dirty_set(dirty_set), .dirty_reset(dirty_reset), .lru_write(lru_write),
        .valid_write(valid_write), .pmem_addr_sel(pmem_addr_sel),
        .save_to_cache_sel(save_to_cache_sel), .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_control #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .lru_out(lru_out), .dirty_mux_out(dirty_mux_out), .pmem_resp(pmem_resp),
        .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .tag_write(s_tag_write), .retain(s_retain), .cache_write(s_cache_write),
        .dirty_set(s_dirty_set), .dirty_reset(s_dirty_reset), .lru_write(s_lru_write),
        .valid_write(s_valid_write), .pmem_addr_sel(s_pmem_addr_sel),
        .save_to_cache_sel(s_save_sel), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] h,
                         input logic lru, input logic dirty, input logic presp);
        mem_read = rd; mem_write = wr; hit = h;
        lru_out = lru; dirty_mux_out = dirty; pmem_resp = presp;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 2'b00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    // Transaction-level model: which pmem transfer (if any) is outstanding,
    // plus ideal saturating counters for both counter widths.
    bit m_wb_busy, m_fill_busy;
    int m_hits, m_misses, m_hits2, m_misses2;

    task automatic model_eval(output logic [11:0] o, output bit nwb, output bit nfill,
                              output bit hit_ev, output bit miss_ev);
        bit wants;
        o = '0; nwb = m_wb_busy; nfill = m_fill_busy; hit_ev = 0; miss_ev = 0;
        wants = mem_read || mem_write;
        if (m_wb_busy) begin
            o = M_PWR | M_ASEL;
            if (pmem_resp) begin nwb = 0; nfill = 1; end
        end else if (m_fill_busy) begin
            o = pmem_resp ? M_FILL_DONE : M_PRD;
            if (pmem_resp) nfill = 0;
        end else if (wants && hit != 2'b00) begin
            hit_ev = 1;
            o = mem_write ? M_WHIT : M_RESP;
            if (hit[1] == lru_out) o = o | M_LRU;
        end else if (wants) begin
            miss_ev = 1;
            if (dirty_mux_out) begin o = M_RET; nwb = 1; end
            else nfill = 1;
        end
    endtask

    typedef struct {
        logic rd, wr;
        logic [1:0] hit;
        logic lru, dirty, presp;
        logic [11:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[9];
        logic [11:0] eo;
        bit nwb, nfill, hev, mev;

        vecs[0] = '{1, 0, 2'b01, 0, 0, 0, M_RESP | M_LRU};
        vecs[1] = '{0, 1, 2'b10, 0, 0, 0, M_WHIT};
        vecs[2] = '{1, 0, 2'b10, 1, 1, 0, M_RESP | M_LRU};
        vecs[3] = '{1, 1, 2'b01, 1, 0, 0, M_WHIT};
        vecs[4] = '{1, 0, 2'b11, 1, 0, 0, M_RESP | M_LRU};
        vecs[5] = '{0, 1, 2'b11, 0, 1, 0, M_WHIT};
        vecs[6] = '{1, 0, 2'b00, 0, 1, 0, M_RET};
        vecs[7] = '{0, 1, 2'b00, 1, 0, 0, 12'h000};
        vecs[8] = '{0, 0, 2'b01, 0, 1, 1, 12'h000};

        do_reset();
        #2;
        check("reset_outs", outs, 12'h000);
        check("reset_counts", {hit_count, miss_count}, 32'h0);

        // IDLE decode table; request removed before the edge so state never moves.
        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].hit, vecs[i].lru, vecs[i].dirty, vecs[i].presp);
            #2;
            check($sformatf("idle_vec%0d", i), outs, vecs[i].exp);
            #1 drive(0, 0, 2'b00, 0, 0, 0);
            tick();
        end
        check("table_counts", {hit_count, miss_count}, 32'h0);

        // Read hit and write hit that complete across an edge.
        drive(1, 0, 2'b01, 0, 0, 0); #2;
        check("read_hit", outs, M_RESP | M_LRU);
        tick(); drive(0, 0, 2'b00, 0, 0, 0); #2;
        check("read_hit_counts", {hit_count, miss_count}, {16'd1, 16'd0});
        check("read_hit_stays_idle", outs, 12'h000);
        drive(0, 1, 2'b10, 0, 0, 0); #2;
        check("write_hit", outs, M_WHIT);
        tick(); drive(0, 0, 2'b00, 0, 0, 0);

        // Clean read miss with a 5-cycle fill, then the re-evaluated hit.
        drive(1, 0, 2'b00, 0, 0, 0); #2;
        check("clean_miss_idle", outs, 12'h000);
        tick();
        for (int c = 1; c <= 5; c++) begin
            pmem_resp = (c == 5); #2;
            check($sformatf("clean_fill_c%0d", c), outs, (c == 5) ? M_FILL_DONE : M_PRD);
            tick();
        end
        pmem_resp = 0; hit = 2'b01; #2;
        check("clean_miss_resp", outs, M_RESP | M_LRU);
        tick(); drive(0, 0, 2'b00, 0, 0, 0); #2;
        check("clean_miss_counts", {hit_count, miss_count}, {16'd3, 16'd1});

        // Dirty write miss: retain, writeback, fill, then a write hit on way1.
        drive(0, 1, 2'b00, 1, 1, 0); #2;
        check("dirty_miss_retain", outs, M_RET);
        tick(); dirty_mux_out = 0;
        for (int c = 1; c <= 3; c++) begin
            pmem_resp = (c == 3); #2;
            check($sformatf("writeback_c%0d", c), outs, M_PWR | M_ASEL);
            tick();
        end
        for (int c = 1; c <= 2; c++) begin
            pmem_resp = (c == 2); #2;
            check($sformatf("dirty_fill_c%0d", c), outs, (c == 2) ? M_FILL_DONE : M_PRD);
            tick();
        end
        pmem_resp = 0; hit = 2'b10; #2;
        check("dirty_miss_resp", outs, M_WHIT | M_LRU);
        tick(); drive(0, 0, 2'b00, 0, 0, 0); #2;
        check("dirty_miss_counts", {hit_count, miss_count}, {16'd4, 16'd2});

        // Request dropped mid-fill: fill finishes, no completion follows.
        drive(1, 0, 2'b00, 0, 0, 0); tick();
        drive(0, 0, 2'b00, 0, 0, 0); #2;
        check("dropped_fill", outs, M_PRD);
        tick(); pmem_resp = 1; #2;
        check("dropped_fill_done", outs, M_FILL_DONE);
        tick(); pmem_resp = 0; #2;
        check("dropped_no_resp", outs, 12'h000);
        tick();
        check("dropped_counts", {hit_count, miss_count}, {16'd4, 16'd3});

        // Asynchronous reset in the middle of a fill.
        drive(1, 0, 2'b00, 0, 0, 0); tick(); #2;
        check("pre_reset_fill", outs, M_PRD);
        #1 rst_n = 0; #1;
        check("async_reset_outs", outs, 12'h000);
        check("async_reset_counts", {hit_count, miss_count}, 32'h0);
        hit = 2'b01; #1 rst_n = 1; #1;
        check("post_reset_hit", outs, M_RESP | M_LRU);
        tick();
        check("post_reset_counts", {hit_count, miss_count}, {16'd1, 16'd0});

        // Four more hits: the 2-bit instance saturates at 3.
        repeat (4) tick();
        drive(0, 0, 2'b00, 0, 0, 0); #2;
        check("sat_small_counts", {s_hit_count, s_miss_count}, {2'd3, 2'd0});
        check("sat_big_counts", {hit_count, miss_count}, {16'd5, 16'd0});

        // Random traffic against the model, from a fresh reset.
        do_reset();
        m_wb_busy = 0; m_fill_busy = 0;
        m_hits = 0; m_misses = 0; m_hits2 = 0; m_misses2 = 0;
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 4) < 3 ? $urandom_range(0, 1) : 0,
                  $urandom_range(0, 4) < 2,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
            #2;
            model_eval(eo, nwb, nfill, hev, mev);
            check($sformatf("rand_outs_%0d", n), outs, eo);
            check($sformatf("rand_counts_%0d", n), {hit_count, miss_count},
                  {16'(m_hits), 16'(m_misses)});
            check($sformatf("rand_small_%0d", n), {s_hit_count, s_miss_count},
                  {2'(m_hits2), 2'(m_misses2)});
            tick();
            m_wb_busy = nwb; m_fill_busy = nfill;
            if (hev) begin
                if (m_hits < 65535) m_hits++;
                if (m_hits2 < 3) m_hits2++;
            end
            if (mev) begin
                if (m_misses < 65535) m_misses++;
                if (m_misses2 < 3) m_misses2++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
